// File: rtl/lcd_ctrl_param.sv
// HD44780-class character LCD write controller, 8- or 4-bit bus.
// Runs power-up init, then writes RS/byte requests with timed en strobes.
module lcd_ctrl_param #(
  parameter int DATA_W       = 8,
  parameter int SETUP_CYC    = 4,
  parameter int EN_HIGH_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int POWERUP_CYC  = 750000,
  parameter int DBG_W        = 4
) (
  input  logic              clk,
  input  logic              rstBt,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rs,
  input  logic [7:0]        req_data,
  output logic [DATA_W-1:0] LCD,
  output logic              en,
  output logic              RS,
  output logic              RW,
  output logic              init_done,
  output logic              busy,
  output logic [DBG_W-1:0]  dbg_state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int SU   = (SETUP_CYC    < 1) ? 1 : SETUP_CYC;
  localparam int EH   = (EN_HIGH_CYC  < 1) ? 1 : EN_HIGH_CYC;
  localparam int CMDW = (CMD_WAIT_CYC < 1) ? 1 : CMD_WAIT_CYC;
  localparam int CLRW = (CLR_WAIT_CYC < 1) ? 1 : CLR_WAIT_CYC;
  localparam int PW   = (POWERUP_CYC  < 1) ? 1 : POWERUP_CYC;
  localparam int MAXV =
    max2(max2(max2(SU + 1, EH), max2(CMDW, CLRW)), PW);
  localparam int CNT_W  = $clog2(MAXV + 1);
  localparam int N_INIT = (DATA_W == 4) ? 9 : 8;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    SETUP    = 3'd1,
    EN_HI    = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4,
    WAIT     = 3'd5,
    IDLE     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim_m1;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             single_q, single_d;
  logic             lo_q, lo_d;
  logic             done_q, done_d;
  logic             tdone, clr;
  logic [8:0]       rom_nxt;

  // {single_nibble, byte}; single nibbles sit in the high nibble
  function automatic logic [8:0] rom(input logic [3:0] i);
    logic [8:0] r;
    r = 9'h000;
    if (DATA_W == 4) begin
      case (i)
        4'd0, 4'd1, 4'd2: r = {1'b1, 8'h30};
        4'd3:             r = {1'b1, 8'h20};
        4'd4:             r = {1'b0, 8'h28};
        4'd5:             r = {1'b0, 8'h08};
        4'd6:             r = {1'b0, 8'h01};
        4'd7:             r = {1'b0, 8'h06};
        4'd8:             r = {1'b0, 8'h0C};
        default:          r = 9'h000;
      endcase
    end else begin
      case (i)
        4'd0, 4'd1, 4'd2: r = {1'b0, 8'h30};
        4'd3:             r = {1'b0, 8'h38};
        4'd4:             r = {1'b0, 8'h08};
        4'd5:             r = {1'b0, 8'h01};
        4'd6:             r = {1'b0, 8'h06};
        4'd7:             r = {1'b0, 8'h0C};
        default:          r = 9'h000;
      endcase
    end
    return r;
  endfunction

  assign clr     = !rs_q && (byte_q[7:2] == 6'd0) && !single_q;
  assign rom_nxt = rom((state_q == PWR_WAIT) ? 4'd0 : idx_q + 4'd1);

  // first SETUP of a byte includes the cycle in which RS/LCD load
  always_comb begin
    lim_m1 = '0;
    unique case (state_q)
      PWR_WAIT: lim_m1 = CNT_W'(PW - 1);
      SETUP:    lim_m1 = lo_q ? CNT_W'(SU - 1) : CNT_W'(SU);
      EN_HI:    lim_m1 = CNT_W'(EH - 1);
      HOLD:     lim_m1 = CNT_W'(SU - 1);
      GAP:      lim_m1 = CNT_W'(SU - 1);
      WAIT:     lim_m1 = clr ? CNT_W'(CLRW - 1) : CNT_W'(CMDW - 1);
      default:  lim_m1 = '0;
    endcase
  end

  assign tdone = (cnt_q == lim_m1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = tdone ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    single_d = single_q;
    lo_d     = lo_q;
    done_d   = done_q;
    unique case (state_q)
      PWR_WAIT: if (tdone) begin
        state_d  = SETUP;
        idx_d    = 4'd0;
        byte_d   = rom_nxt[7:0];
        single_d = rom_nxt[8];
        rs_d     = 1'b0;
        lo_d     = 1'b0;
      end
      SETUP: if (tdone) state_d = EN_HI;
      EN_HI: if (tdone) state_d = HOLD;
      HOLD: if (tdone) begin
        if (DATA_W == 4 && !lo_q && !single_q) state_d = GAP;
        else state_d = WAIT;
      end
      GAP: if (tdone) begin
        state_d = SETUP;
        lo_d    = 1'b1;
      end
      WAIT: if (tdone) begin
        if (done_q) begin
          state_d = IDLE;
        end else if (idx_q == 4'(N_INIT - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d  = SETUP;
          idx_d    = idx_q + 4'd1;
          byte_d   = rom_nxt[7:0];
          single_d = rom_nxt[8];
          rs_d     = 1'b0;
          lo_d     = 1'b0;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (req_valid && done_q) begin
          state_d  = SETUP;
          rs_d     = req_rs;
          byte_d   = req_data;
          single_d = 1'b0;
          lo_d     = 1'b0;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rstBt) begin
    if (rstBt) begin
      state_q  <= PWR_WAIT;
      cnt_q    <= '0;
      idx_q    <= 4'd0;
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
      single_q <= 1'b0;
      lo_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      single_q <= single_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  generate
    if (DATA_W == 4) begin : g_w4
      assign LCD = lo_q ? byte_q[3:0] : byte_q[7:4];
    end else if (DATA_W == 8) begin : g_w8
      assign LCD = byte_q;
    end else begin : g_bad
      $error("lcd_ctrl_param: DATA_W must be 8 or 4");
      assign LCD = '0;
    end
  endgenerate

  assign en        = (state_q == EN_HI);
  assign RS        = rs_q;
  assign RW        = 1'b0;
  assign init_done = done_q;
  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == IDLE) && done_q;
  assign dbg_state = DBG_W'(state_q);

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: 8-bit and 4-bit instances against a
// timing/pulse model derived from the bus protocol rules.
module tb_lcd_ctrl_param;

  localparam int S   = 2;
  localparam int E   = 3;
  localparam int CMD = 10;
  localparam int CLR = 40;
  localparam int PWR = 20;

  typedef struct packed {
    int       rise;
    int       width;
    logic [7:0] lcd;
    logic     rs;
    logic     stable;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  logic       vld[2];
  logic       rsi[2];
  logic [7:0] dat[2];

  logic       rdy8, rdy4, en8, en4, rso8, rso4, rw8, rw4;
  logic       id8, id4, bz8, bz4;
  logic [7:0] lcd8;
  logic [3:0] lcd4, dbg8, dbg4;

  logic       en_w[2], rdy_w[2], rs_w[2], rw_w[2], id_w[2], bz_w[2];
  logic [7:0] lcd_w[2];
  logic [3:0] dbg_w[2];

  pulse_t obs_q[2][$];
  pulse_t exp_q[2][$];
  int     rdy_q[2][$];

  int n_chk  = 0;
  int n_fail = 0;
  int rw_bad = 0;

  lcd_ctrl_param #(
    .DATA_W(8), .SETUP_CYC(S), .EN_HIGH_CYC(E), .CMD_WAIT_CYC(CMD),
    .CLR_WAIT_CYC(CLR), .POWERUP_CYC(PWR), .DBG_W(4)
  ) u_w8 (
    .clk(clk), .rstBt(rst), .req_valid(vld[0]), .req_ready(rdy8),
    .req_rs(rsi[0]), .req_data(dat[0]), .LCD(lcd8), .en(en8),
    .RS(rso8), .RW(rw8), .init_done(id8), .busy(bz8),
    .dbg_state(dbg8)
  );

  lcd_ctrl_param #(
    .DATA_W(4), .SETUP_CYC(S), .EN_HIGH_CYC(E), .CMD_WAIT_CYC(CMD),
    .CLR_WAIT_CYC(CLR), .POWERUP_CYC(PWR), .DBG_W(4)
  ) u_w4 (
    .clk(clk), .rstBt(rst), .req_valid(vld[1]), .req_ready(rdy4),
    .req_rs(rsi[1]), .req_data(dat[1]), .LCD(lcd4), .en(en4),
    .RS(rso4), .RW(rw4), .init_done(id4), .busy(bz4),
    .dbg_state(dbg4)
  );

  assign en_w[0]  = en8;   assign en_w[1]  = en4;
  assign rdy_w[0] = rdy8;  assign rdy_w[1] = rdy4;
  assign rs_w[0]  = rso8;  assign rs_w[1]  = rso4;
  assign rw_w[0]  = rw8;   assign rw_w[1]  = rw4;
  assign id_w[0]  = id8;   assign id_w[1]  = id4;
  assign bz_w[0]  = bz8;   assign bz_w[1]  = bz4;
  assign lcd_w[0] = lcd8;  assign lcd_w[1] = {4'h0, lcd4};
  assign dbg_w[0] = dbg8;  assign dbg_w[1] = dbg4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse recorder: rise cycle, width, latched value, stability
  logic   en_p[2], rdy_p[2];
  pulse_t cur[2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        en_p[i]  = 1'b0;
        rdy_p[i] = 1'b0;
      end else begin
        if (en_w[i] && !en_p[i]) begin
          cur[i].rise   = cyc;
          cur[i].lcd    = lcd_w[i];
          cur[i].rs     = rs_w[i];
          cur[i].stable = 1'b1;
          cur[i].width  = 0;
        end else if (en_w[i] && en_p[i]) begin
          if (lcd_w[i] != cur[i].lcd || rs_w[i] != cur[i].rs)
            cur[i].stable = 1'b0;
        end
        if (!en_w[i] && en_p[i]) begin
          cur[i].width = cyc - cur[i].rise;
          obs_q[i].push_back(cur[i]);
        end
        if (rdy_w[i] && !rdy_p[i]) rdy_q[i].push_back(cyc);
        if (rw_w[i]) rw_bad++;
        en_p[i]  = en_w[i];
        rdy_p[i] = rdy_w[i];
      end
    end
  end

  task automatic chk(input string tag, input longint got,
                     input longint want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // one byte (or single nibble) starting at load edge t; t -> end edge
  task automatic model_xfer(input int i, inout int t, input logic rs,
                            input logic [7:0] b, input logic single);
    int     w;
    pulse_t p;
    w = (!rs && b[7:2] == 6'd0 && !single) ? CLR : CMD;
    p.width  = E;
    p.rs     = rs;
    p.stable = 1'b1;
    p.rise   = t + S + 1;
    if (i == 0) begin
      p.lcd = b;
      exp_q[i].push_back(p);
      t = t + 1 + 2 * S + E + w;
    end else if (single) begin
      p.lcd = {4'h0, b[3:0]};
      exp_q[i].push_back(p);
      t = t + 1 + 2 * S + E + w;
    end else begin
      p.lcd = {4'h0, b[7:4]};
      exp_q[i].push_back(p);
      p.rise = p.rise + E + S + S + S;
      p.lcd  = {4'h0, b[3:0]};
      exp_q[i].push_back(p);
      t = t + 1 + 2 * S + E + 3 * S + E + w;
    end
  endtask

  task automatic model_init(input int i, inout int t);
    logic [7:0] r8[8];
    logic [7:0] r4[5];
    r8 = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    r4 = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
    if (i == 0) begin
      for (int k = 0; k < 8; k++) model_xfer(0, t, 1'b0, r8[k], 1'b0);
    end else begin
      model_xfer(1, t, 1'b0, 8'h03, 1'b1);
      model_xfer(1, t, 1'b0, 8'h03, 1'b1);
      model_xfer(1, t, 1'b0, 8'h03, 1'b1);
      model_xfer(1, t, 1'b0, 8'h02, 1'b1);
      for (int k = 0; k < 5; k++) model_xfer(1, t, 1'b0, r4[k], 1'b0);
    end
  endtask

  task automatic cmp(input int i, input string ctx);
    int n;
    string nm;
    nm = $sformatf("%s_w%0d", ctx, (i == 0) ? 8 : 4);
    chk({nm, "_npulse"}, obs_q[i].size(), exp_q[i].size());
    n = (obs_q[i].size() < exp_q[i].size()) ?
        obs_q[i].size() : exp_q[i].size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_p%0d_rise", nm, k), obs_q[i][k].rise,
          exp_q[i][k].rise);
      chk($sformatf("%s_p%0d_width", nm, k), obs_q[i][k].width,
          exp_q[i][k].width);
      chk($sformatf("%s_p%0d_lcd", nm, k), obs_q[i][k].lcd,
          exp_q[i][k].lcd);
      chk($sformatf("%s_p%0d_rs", nm, k), obs_q[i][k].rs,
          exp_q[i][k].rs);
      chk($sformatf("%s_p%0d_stable", nm, k), obs_q[i][k].stable,
          exp_q[i][k].stable);
    end
    obs_q[i].delete();
    exp_q[i].delete();
  endtask

  task automatic chk_rst();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_en_%0d", i), en_w[i], 0);
      chk($sformatf("rst_rs_%0d", i), rs_w[i], 0);
      chk($sformatf("rst_rw_%0d", i), rw_w[i], 0);
      chk($sformatf("rst_lcd_%0d", i), lcd_w[i], 0);
      chk($sformatf("rst_rdy_%0d", i), rdy_w[i], 0);
      chk($sformatf("rst_idone_%0d", i), id_w[i], 0);
      chk($sformatf("rst_busy_%0d", i), bz_w[i], 1);
      chk($sformatf("rst_dbg_%0d", i), dbg_w[i], 0);
    end
  endtask

  task automatic run_init();
    int  t, rel, n;
    int  tend[2];
    logic seen[2];
    rst = 1'b1;
    #1;
    chk_rst();
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      obs_q[i].delete();
      exp_q[i].delete();
      rdy_q[i].delete();
      // requests during init must be ignored
      vld[i]  = 1'b1;
      rsi[i]  = 1'($urandom);
      dat[i]  = 8'($urandom);
      seen[i] = 1'b0;
    end
    rst = 1'b0;
    rel = cyc;
    for (int i = 0; i < 2; i++) begin
      t = rel + PWR;
      model_init(i, t);
      tend[i] = t;
    end
    n = 0;
    while (!(seen[0] && seen[1]) && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
      for (int i = 0; i < 2; i++) begin
        if (!seen[i] && rdy_w[i]) begin
          vld[i]  = 1'b0;
          seen[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      chk($sformatf("init_rdy_seen_%0d", i), seen[i], 1);
      chk($sformatf("init_idone_%0d", i), id_w[i], 1);
      chk($sformatf("init_rdy_time_%0d", i),
          (rdy_q[i].size() > 0) ? rdy_q[i].pop_front() : -1, tend[i]);
      cmp(i, "init");
    end
  endtask

  task automatic do_req(input int i, input logic rs, input logic [7:0] b,
                        input int hold);
    int n, t;
    vld[i] = 1'b1;
    rsi[i] = rs;
    dat[i] = b;
    n = 0;
    while (!rdy_w[i] && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy_w[i]) begin
      chk($sformatf("accept_timeout_%0d", i), 0, 1);
      vld[i] = 1'b0;
      return;
    end
    t = cyc + 1;
    model_xfer(i, t, rs, b, 1'b0);
    @(negedge clk);
    #1;
    chk($sformatf("rdy_drop_%0d", i), rdy_w[i], 0);
    chk($sformatf("busy_%0d", i), bz_w[i], 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
    end
    vld[i] = 1'b0;
    n = 0;
    while (!rdy_w[i] && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("rdy_time_%0d_%02h", i, b),
        (rdy_q[i].size() > 0) ? rdy_q[i].pop_front() : -1, t);
    cmp(i, $sformatf("req%02h", b));
  endtask

  initial begin
    int n;
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      rsi[i] = 1'b0;
      dat[i] = 8'h00;
    end
    #2;
    run_init();

    do_req(0, 1'b1, 8'h41, 3);
    do_req(1, 1'b1, 8'hA5, 3);
    for (int i = 0; i < 2; i++) begin
      do_req(i, 1'b0, 8'h01, 12);
      do_req(i, 1'b0, 8'h80, 12);
    end
    for (int k = 0; k < 24; k++) begin
      b = ($urandom % 4 == 0) ? 8'($urandom % 4) : 8'($urandom);
      do_req(k % 2, 1'($urandom), b, int'($urandom % 13));
    end

    // abort a transfer while en is high
    vld[0] = 1'b1;
    rsi[0] = 1'b1;
    dat[0] = 8'h77;
    n = 0;
    while (!en_w[0] && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_en_seen", en_w[0], 1);
    vld[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("abort_en", en_w[0], 0);
    chk("abort_idone", id_w[0], 0);
    chk("abort_rdy", rdy_w[0], 0);
    chk("abort_idone4", id_w[1], 0);
    run_init();

    do_req(0, 1'b1, 8'h42, 0);
    do_req(1, 1'b0, 8'h02, 0);

    chk("rw_always_zero", rw_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
